// File: rtl/ram8_arbiter.sv
// ram8_arbiter
//   Two-requester arbiter in front of an internal 8 x 16-bit store.
//   Grants are combinational and the granted access happens on the next
//   rising clock edge. Ties go round-robin. Read data is registered per
//   requester and marked by a one-cycle rvalid pulse.
//
//   Optional feature: define RAM8_ARB_LOCK_EN to build the lock FSM.
//   With the lock FSM, a requester can hold the grant for up to LOCK_MAX
//   consecutive cycles. Without RAM8_ARB_LOCK_EN, lock0/lock1 are ignored.
//
// Ports
//   clock            rising-edge clock
//   reset_n          asynchronous active-low reset (store is not cleared)
//   reqN             requester N wants one access this cycle
//   weN              1 = write, 0 = read (qualified by reqN)
//   lockN            requester N asks to keep the grant next cycle
//   addrN  [2:0]     word address
//   wdataN [15:0]    write data
//   gntN             combinational grant
//   rdataN [15:0]    registered read data
//   rvalidN          one-cycle pulse marking new rdataN
module ram8_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        we0,
  input  logic        lock0,
  input  logic [2:0]  addr0,
  input  logic [15:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic        lock1,
  input  logic [2:0]  addr1,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        rvalid0,
  output logic        rvalid1
);

  logic [15:0] mem_q [8];

  // rr_q names the requester that wins a tie (0 after reset)
  logic        rr_q, rr_d;
  logic        lock_gnt0, lock_gnt1;

  logic        mem_we;
  logic [2:0]  mem_addr;
  logic [15:0] mem_wdata;

  logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

`ifdef RAM8_ARB_LOCK_EN
  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} lock_state_e;

  lock_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  // one-hot: requester barred from re-locking the cycle after a LOCK_MAX exit
  logic [1:0]  ban_q, ban_d;

  assign lock_gnt0 = (state_q == LOCKED0) && req0;
  assign lock_gnt1 = (state_q == LOCKED1) && req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ban_d   = 2'b00;
    case (state_q)
      UNLOCKED: begin
        if (gnt0 && lock0 && !ban_q[0]) begin
          state_d = LOCKED0;
          cnt_d   = 4'd1;
        end else if (gnt1 && lock1 && !ban_q[1]) begin
          state_d = LOCKED1;
          cnt_d   = 4'd1;
        end
      end
      LOCKED0: begin
        if (!req0 || !lock0) begin
          state_d = UNLOCKED;
          cnt_d   = 4'd0;
        end else if (cnt_q + 4'd1 == 4'(LOCK_MAX)) begin
          state_d = UNLOCKED;
          cnt_d   = 4'd0;
          ban_d   = 2'b01;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      LOCKED1: begin
        if (!req1 || !lock1) begin
          state_d = UNLOCKED;
          cnt_d   = 4'd0;
        end else if (cnt_q + 4'd1 == 4'(LOCK_MAX)) begin
          state_d = UNLOCKED;
          cnt_d   = 4'd0;
          ban_d   = 2'b10;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = UNLOCKED;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UNLOCKED;
      cnt_q   <= 4'd0;
      ban_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ban_q   <= ban_d;
    end
  end
`else
  logic unused_lock;

  assign lock_gnt0   = 1'b0;
  assign lock_gnt1   = 1'b0;
  assign unused_lock = ^{lock0, lock1, 4'(LOCK_MAX)};
`endif

  // A held lock overrides round-robin; otherwise ties follow rr_q
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_gnt0) begin
      gnt0 = 1'b1;
    end else if (lock_gnt1) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      gnt0 = ~rr_q;
      gnt1 = rr_q;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Store port driven from the granted requester only; the write enable is
  // also gated by reset_n so no write lands on an edge during reset
  always_comb begin
    mem_addr  = gnt1 ? addr1 : addr0;
    mem_wdata = gnt1 ? wdata1 : wdata0;
    mem_we    = reset_n && ((gnt0 && we0) || (gnt1 && we1));
    rr_d      = rr_q;
    if (gnt0) begin
      rr_d = 1'b1;
    end else if (gnt1) begin
      rr_d = 1'b0;
    end
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
    rdata0_d  = rvalid0_d ? mem_q[mem_addr] : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_q[mem_addr] : rdata1_q;
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q      <= 1'b0;
      rdata0_q  <= 16'h0000;
      rdata1_q  <= 16'h0000;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule
